// File: rtl/flght_seq_pkg.sv
// Shared types and constants for the flight startup/shutdown sequencer.
package flght_seq_pkg;

    // Thrust datapath width (unsigned thrust 0..511).
    localparam int THRST_W = 9;

    // Calibration timeout counter widths: full hardware and shortened simulation.
    localparam int CAL_TMO_W     = 20;
    localparam int CAL_TMO_W_SIM = 10;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_CAL     = 3'd1,
        ST_RAMP_UP = 3'd2,
        ST_RUN     = 3'd3,
        ST_RAMP_DN = 3'd4
    } seq_state_t;

endpackage : flght_seq_pkg

// File: rtl/flght_seq_thrst_slew.sv
// Combinational slew limiter: moves cur toward tgt by at most step.
// Arithmetic is done one bit wider than thrust so the result is naturally
// clamped to 0..511 (it never overshoots the target, which is in range).
module thrst_slew
    import flght_seq_pkg::*;
(
    input  logic [THRST_W-1:0] cur,
    input  logic [THRST_W-1:0] tgt,
    input  logic [THRST_W:0]   step,
    output logic [THRST_W-1:0] nxt,
    output logic               at_tgt
);

    logic [THRST_W:0] cur_w;
    logic [THRST_W:0] tgt_w;
    logic [THRST_W:0] diff_w;
    logic [THRST_W:0] move_w;

    // Pick the next value: land exactly on target when within one step,
    // otherwise move a full step in the target's direction.
    always_comb begin
        cur_w  = {1'b0, cur};
        tgt_w  = {1'b0, tgt};
        diff_w = '0;
        move_w = cur_w;
        nxt    = cur;
        if (tgt_w >= cur_w) begin
            diff_w = tgt_w - cur_w;
            move_w = cur_w + step;
        end else begin
            diff_w = cur_w - tgt_w;
            move_w = cur_w - step;
        end
        if (diff_w <= step) begin
            nxt = tgt;
        end else begin
            nxt = move_w[THRST_W-1:0];
        end
        at_tgt = (nxt == tgt);
    end

endmodule : thrst_slew

// File: rtl/flght_seq.sv
// Startup/shutdown sequencer for flight control: calibration with timeout,
// slew-limited spin-up, and slew-limited controlled or emergency spin-down.
module flght_seq
    import flght_seq_pkg::*;
#(
    parameter int RAMP_STEP = 16,
    parameter bit FAST_SIM  = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               strt_cal,
    input  logic               cal_done,
    input  logic               vld,
    input  logic               motors_off,
    input  logic               emer_lnd,
    input  logic [THRST_W-1:0] thrst_cmd,
    output logic               inertial_cal,
    output logic [THRST_W-1:0] thrst,
    output logic               mtrs_off,
    output logic               running,
    output logic               cal_err
);

    localparam int TMO_W  = FAST_SIM ? CAL_TMO_W_SIM : CAL_TMO_W;
    localparam int STEP_W = THRST_W + 1;
    localparam logic [STEP_W-1:0] STEP_NORM = STEP_W'(RAMP_STEP);
    localparam logic [STEP_W-1:0] STEP_EMER = STEP_W'(2 * RAMP_STEP);

    seq_state_t          state_q, state_d;
    logic [THRST_W-1:0]  thrst_q, thrst_d;
    logic [TMO_W-1:0]    timer_q, timer_d;
    logic                cal_err_q, cal_err_d;
    logic                inertial_cal_q, inertial_cal_d;
    logic                mtrs_off_q, mtrs_off_d;
    logic                running_q, running_d;

    logic                stop_req;
    logic [THRST_W-1:0]  slew_tgt;
    logic [STEP_W-1:0]   slew_step;
    logic [THRST_W-1:0]  slew_nxt;
    logic                slew_at_tgt;

    assign stop_req = motors_off | emer_lnd;

    // Ramp-down heads for zero (double step on emergency); ramp-up follows the slider.
    assign slew_tgt  = (state_q == ST_RAMP_DN) ? '0 : thrst_cmd;
    assign slew_step = (state_q == ST_RAMP_DN && emer_lnd) ? STEP_EMER : STEP_NORM;

    thrst_slew u_slew (
        .cur    (thrst_q),
        .tgt    (slew_tgt),
        .step   (slew_step),
        .nxt    (slew_nxt),
        .at_tgt (slew_at_tgt)
    );

    // State and registered-output flops; reset lands in OFF with ESCs forced off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_OFF;
            thrst_q        <= '0;
            timer_q        <= '0;
            cal_err_q      <= 1'b0;
            inertial_cal_q <= 1'b0;
            mtrs_off_q     <= 1'b1;
            running_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            thrst_q        <= thrst_d;
            timer_q        <= timer_d;
            cal_err_q      <= cal_err_d;
            inertial_cal_q <= inertial_cal_d;
            mtrs_off_q     <= mtrs_off_d;
            running_q      <= running_d;
        end
    end

    // Next-state, thrust, timer and sticky-error logic.
    always_comb begin
        state_d   = state_q;
        thrst_d   = thrst_q;
        timer_d   = '0;
        cal_err_d = cal_err_q;
        case (state_q)
            ST_OFF: begin
                thrst_d = '0;
                // A simultaneous shutdown request vetoes the start.
                if (strt_cal && !stop_req) begin
                    state_d   = ST_CAL;
                    cal_err_d = 1'b0;
                end
            end
            ST_CAL: begin
                thrst_d = '0;
                timer_d = timer_q + TMO_W'(1);
                if (stop_req) begin
                    state_d = ST_OFF;
                end else if (cal_done) begin
                    state_d = ST_RAMP_UP;
                end else if (&timer_q) begin
                    state_d   = ST_OFF;
                    cal_err_d = 1'b1;
                end
            end
            ST_RAMP_UP: begin
                if (stop_req) begin
                    state_d = ST_RAMP_DN;
                end else if (vld) begin
                    thrst_d = slew_nxt;
                    if (slew_at_tgt) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (stop_req) begin
                    state_d = ST_RAMP_DN;
                end else begin
                    thrst_d = thrst_cmd;
                end
            end
            ST_RAMP_DN: begin
                // Once thrust is zero, drop to OFF on the following clock.
                if (thrst_q == '0) begin
                    state_d = ST_OFF;
                end else if (vld) begin
                    thrst_d = slew_nxt;
                end
            end
            default: begin
                state_d = ST_OFF;
                thrst_d = '0;
            end
        endcase
    end

    // Moore outputs decoded from the next state so they register alongside it.
    always_comb begin
        inertial_cal_d = (state_d == ST_CAL);
        mtrs_off_d     = (state_d == ST_OFF);
        running_d      = (state_d == ST_RUN);
    end

    assign inertial_cal = inertial_cal_q;
    assign thrst        = thrst_q;
    assign mtrs_off     = mtrs_off_q;
    assign running      = running_q;
    assign cal_err      = cal_err_q;

endmodule : flght_seq

// File: tb/tb_flght_seq.sv
// Directed testbench for flght_seq (RAMP_STEP=16, FAST_SIM=1).
module tb_flght_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       strt_cal;
    logic       cal_done;
    logic       vld;
    logic       motors_off;
    logic       emer_lnd;
    logic [8:0] thrst_cmd;
    logic       inertial_cal;
    logic [8:0] thrst;
    logic       mtrs_off;
    logic       running;
    logic       cal_err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Packed observation: {mtrs_off, inertial_cal, running, cal_err, thrst}
    logic [12:0] obs;
    assign obs = {mtrs_off, inertial_cal, running, cal_err, thrst};

    flght_seq #(.RAMP_STEP(16), .FAST_SIM(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .strt_cal     (strt_cal),
        .cal_done     (cal_done),
        .vld          (vld),
        .motors_off   (motors_off),
        .emer_lnd     (emer_lnd),
        .thrst_cmd    (thrst_cmd),
        .inertial_cal (inertial_cal),
        .thrst        (thrst),
        .mtrs_off     (mtrs_off),
        .running      (running),
        .cal_err      (cal_err)
    );

    always #5 clk = ~clk;

    // Advance n clocks; inputs are changed and outputs sampled 1ns after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic vld_pulse();
        vld = 1'b1;
        tick(1);
        vld = 1'b0;
    endtask

    // Calibrate and ramp to thrst_cmd with a fixed number of readings.
    task automatic go_run(input int nvld);
        strt_cal = 1'b1; tick(1); strt_cal = 1'b0;
        tick(2);
        cal_done = 1'b1; tick(1); cal_done = 1'b0;
        repeat (nvld) begin
            tick(2);
            vld_pulse();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        chk_cnt++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 9'd0})
            $display("FAIL reset_hold: got %b want %b", obs, {1'b1, 1'b0, 1'b0, 1'b0, 9'd0});
        else pass_cnt++;
        rst_n = 1'b1;
        tick(2);
        chk_cnt++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 9'd0})
            $display("FAIL reset_idle: got %b want %b", obs, {1'b1, 1'b0, 1'b0, 1'b0, 9'd0});
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_cal_ramp_up();
        logic [8:0] exp_t;
        logic [8:0] prev_t;
        thrst_cmd = 9'd100;
        strt_cal = 1'b1; tick(1); strt_cal = 1'b0;
        chk_cnt++;
        if (obs !== {1'b0, 1'b1, 1'b0, 1'b0, 9'd0})
            $display("FAIL cal_enter: got %b want %b", obs, {1'b0, 1'b1, 1'b0, 1'b0, 9'd0});
        else pass_cnt++;
        // 49 more clocks in CAL, with a vld that must be ignored.
        tick(20);
        vld_pulse();
        tick(28);
        chk_cnt++;
        if (obs !== {1'b0, 1'b1, 1'b0, 1'b0, 9'd0})
            $display("FAIL cal_49clk: got %b want %b", obs, {1'b0, 1'b1, 1'b0, 1'b0, 9'd0});
        else pass_cnt++;
        cal_done = 1'b1; tick(1); cal_done = 1'b0;
        chk_cnt++;
        if (obs !== {1'b0, 1'b0, 1'b0, 1'b0, 9'd0})
            $display("FAIL cal_exit: got %b want %b", obs, {1'b0, 1'b0, 1'b0, 1'b0, 9'd0});
        else pass_cnt++;
        prev_t = 9'd0;
        for (int i = 0; i < 7; i++) begin
            tick(9);
            chk_cnt++;
            if (thrst !== prev_t)
                $display("FAIL ramp_up_hold%0d: got %0d want %0d", i, thrst, prev_t);
            else pass_cnt++;
            vld_pulse();
            exp_t = (i == 6) ? 9'd100 : 9'(16 * (i + 1));
            chk_cnt++;
            if (obs !== {1'b0, 1'b0, (i == 6), 1'b0, exp_t})
                $display("FAIL ramp_up_step%0d: got %b want %b", i, obs, {1'b0, 1'b0, (i == 6), 1'b0, exp_t});
            else pass_cnt++;
            $display("ramp_up vld %0d thrst=%0d running=%0d", i + 1, thrst, running);
            prev_t = exp_t;
        end
        // RUN follows the slider every clock.
        thrst_cmd = 9'd150; tick(1);
        chk_cnt++;
        if (obs !== {1'b0, 1'b0, 1'b1, 1'b0, 9'd150})
            $display("FAIL run_follow: got %b want %b", obs, {1'b0, 1'b0, 1'b1, 1'b0, 9'd150});
        else pass_cnt++;
        thrst_cmd = 9'd100; tick(1);
        // strt_cal ignored in RUN.
        strt_cal = 1'b1; tick(1); strt_cal = 1'b0;
        chk_cnt++;
        if (obs !== {1'b0, 1'b0, 1'b1, 1'b0, 9'd100})
            $display("FAIL run_ign_strt: got %b want %b", obs, {1'b0, 1'b0, 1'b1, 1'b0, 9'd100});
        else pass_cnt++;
    endtask

    task automatic test_ramp_dn();
        logic [8:0] exp_t;
        motors_off = 1'b1; tick(1); motors_off = 1'b0;
        thrst_cmd = 9'd300;
        chk_cnt++;
        if (obs !== {1'b0, 1'b0, 1'b0, 1'b0, 9'd100})
            $display("FAIL dn_enter: got %b want %b", obs, {1'b0, 1'b0, 1'b0, 1'b0, 9'd100});
        else pass_cnt++;
        for (int i = 0; i < 7; i++) begin
            tick(3);
            vld_pulse();
            exp_t = (i == 6) ? 9'd0 : 9'(100 - 16 * (i + 1));
            chk_cnt++;
            if (obs !== {1'b0, 1'b0, 1'b0, 1'b0, exp_t})
                $display("FAIL dn_step%0d: got %b want %b", i, obs, {1'b0, 1'b0, 1'b0, 1'b0, exp_t});
            else pass_cnt++;
            $display("ramp_dn vld %0d thrst=%0d", i + 1, thrst);
        end
        tick(1);
        chk_cnt++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 9'd0})
            $display("FAIL dn_off: got %b want %b", obs, {1'b1, 1'b0, 1'b0, 1'b0, 9'd0});
        else pass_cnt++;
    endtask

    task automatic test_emer();
        logic [8:0] exp_t;
        thrst_cmd = 9'd100;
        go_run(7);
        chk_cnt++;
        if (obs !== {1'b0, 1'b0, 1'b1, 1'b0, 9'd100})
            $display("FAIL emer_run: got %b want %b", obs, {1'b0, 1'b0, 1'b1, 1'b0, 9'd100});
        else pass_cnt++;
        emer_lnd = 1'b1; tick(1);
        for (int i = 0; i < 4; i++) begin
            tick(2);
            vld_pulse();
            exp_t = (i == 3) ? 9'd0 : 9'(100 - 32 * (i + 1));
            chk_cnt++;
            if (obs !== {1'b0, 1'b0, 1'b0, 1'b0, exp_t})
                $display("FAIL emer_step%0d: got %b want %b", i, obs, {1'b0, 1'b0, 1'b0, 1'b0, exp_t});
            else pass_cnt++;
            $display("emer vld %0d thrst=%0d", i + 1, thrst);
        end
        tick(1);
        chk_cnt++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 9'd0})
            $display("FAIL emer_off: got %b want %b", obs, {1'b1, 1'b0, 1'b0, 1'b0, 9'd0});
        else pass_cnt++;
        emer_lnd = 1'b0;
    endtask

    task automatic test_cal_timeout();
        strt_cal = 1'b1; tick(1); strt_cal = 1'b0;
        tick(1023);
        chk_cnt++;
        if (obs !== {1'b0, 1'b1, 1'b0, 1'b0, 9'd0})
            $display("FAIL tmo_before: got %b want %b", obs, {1'b0, 1'b1, 1'b0, 1'b0, 9'd0});
        else pass_cnt++;
        tick(1);
        chk_cnt++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b1, 9'd0})
            $display("FAIL tmo_expire: got %b want %b", obs, {1'b1, 1'b0, 1'b0, 1'b1, 9'd0});
        else pass_cnt++;
        // strt_cal together with motors_off is refused; error stays.
        tick(3);
        strt_cal = 1'b1; motors_off = 1'b1; tick(1);
        strt_cal = 1'b0; motors_off = 1'b0;
        chk_cnt++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b1, 9'd0})
            $display("FAIL tmo_sticky: got %b want %b", obs, {1'b1, 1'b0, 1'b0, 1'b1, 9'd0});
        else pass_cnt++;
        strt_cal = 1'b1; tick(1); strt_cal = 1'b0;
        chk_cnt++;
        if (obs !== {1'b0, 1'b1, 1'b0, 1'b0, 9'd0})
            $display("FAIL tmo_clear: got %b want %b", obs, {1'b0, 1'b1, 1'b0, 1'b0, 9'd0});
        else pass_cnt++;
        $display("cal timeout sequence cal_err=%0d", cal_err);
    endtask

    // Continues from CAL left by test_cal_timeout.
    task automatic test_cal_abort();
        cal_done = 1'b1; motors_off = 1'b1; tick(1);
        cal_done = 1'b0; motors_off = 1'b0;
        chk_cnt++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 9'd0})
            $display("FAIL abort_off: got %b want %b", obs, {1'b1, 1'b0, 1'b0, 1'b0, 9'd0});
        else pass_cnt++;
        // cal_done and vld ignored in OFF.
        thrst_cmd = 9'd50;
        cal_done = 1'b1; tick(1); cal_done = 1'b0;
        vld_pulse();
        tick(1);
        chk_cnt++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 9'd0})
            $display("FAIL off_ignore: got %b want %b", obs, {1'b1, 1'b0, 1'b0, 1'b0, 9'd0});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        thrst_cmd = 9'd200;
        go_run(13);
        chk_cnt++;
        if (obs !== {1'b0, 1'b0, 1'b1, 1'b0, 9'd200})
            $display("FAIL rst_run: got %b want %b", obs, {1'b0, 1'b0, 1'b1, 1'b0, 9'd200});
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 9'd0})
            $display("FAIL rst_async: got %b want %b", obs, {1'b1, 1'b0, 1'b0, 1'b0, 9'd0});
        else pass_cnt++;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        chk_cnt++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 9'd0})
            $display("FAIL rst_after: got %b want %b", obs, {1'b1, 1'b0, 1'b0, 1'b0, 9'd0});
        else pass_cnt++;
    endtask

    initial begin
        rst_n      = 1'b0;
        strt_cal   = 1'b0;
        cal_done   = 1'b0;
        vld        = 1'b0;
        motors_off = 1'b0;
        emer_lnd   = 1'b0;
        thrst_cmd  = 9'd0;
        test_reset();
        test_cal_ramp_up();
        test_ramp_dn();
        test_emer();
        test_cal_timeout();
        test_cal_abort();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_flght_seq
